// File: rtl/host_mem_if.sv
// Host-memory request/response bundle: byte-masked writes, in-order reads.
// master = requester side, slave = memory responder side.
interface host_mem_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    logic                  wr_cmd_rdy;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [MASK_WIDTH-1:0] wr_datastrb;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_cmd_rdy;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_vld;

    modport master (
        input  wr_cmd_rdy, rd_cmd_rdy, rd_data, rd_data_vld,
        output wr_data, wr_datastrb, wr_addr, rd_en, rd_addr
    );

    modport slave (
        output wr_cmd_rdy, rd_cmd_rdy, rd_data, rd_data_vld,
        input  wr_data, wr_datastrb, wr_addr, rd_en, rd_addr
    );
endinterface

// File: rtl/host_mem_resp_model.sv
// Host-memory responder: masked writes, fixed-latency in-order reads, outstanding-read cap.
// Optional random ready throttling via macro HOST_MEM_MODEL_BACKPRESSURE_EN.
module host_mem_resp_model #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 64,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_DEPTH      = 1024,
    parameter int RD_LATENCY     = 8,
    parameter int RD_OUTSTANDING = 4
) (
    input logic       clk,
    input logic       rst_n,
    host_mem_if.slave mem
);
    localparam int OFS   = $clog2(MASK_WIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(RD_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(RD_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_acc, rd_acc, ret;
    logic                  wr_bp_ok, rd_bp_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    // Only the word-index bits of each address matter; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.wr_addr, mem.rd_addr};

`ifdef HOST_MEM_MODEL_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        wr_bp_ok = (lfsr_q[1:0] != 2'b00);
        rd_bp_ok = (lfsr_q[3:2] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign wr_bp_ok = 1'b1;
    assign rd_bp_ok = 1'b1;
`endif

    assign mem.wr_cmd_rdy  = wr_bp_ok;
    assign mem.rd_cmd_rdy  = (cnt_q < MAX_OUT) && rd_bp_ok;
    assign mem.rd_data     = data_q[RD_LATENCY-1];
    assign mem.rd_data_vld = vld_q[RD_LATENCY-1];

    always_comb begin
        wr_idx  = mem.wr_addr[OFS +: IDX_W];
        rd_idx  = mem.rd_addr[OFS +: IDX_W];
        wr_acc  = (mem.wr_datastrb != '0) && mem.wr_cmd_rdy;
        rd_acc  = mem.rd_en && mem.rd_cmd_rdy;
        ret     = vld_q[RD_LATENCY-1];
        // Same-cycle write to the read word is merged in before sampling.
        rd_word = mem_q[rd_idx];
        if (wr_acc && (wr_idx == rd_idx)) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (mem.wr_datastrb[b]) rd_word[8*b +: 8] = mem.wr_data[8*b +: 8];
            end
        end
    end

    // Each data stage loads only behind a valid, so the last stage holds the
    // most recent return while rd_data_vld is low.
    always_comb begin
        vld_d     = {vld_q[RD_LATENCY-2:0], rd_acc};
        data_d[0] = rd_acc ? rd_word : data_q[0];
        for (int k = 1; k < RD_LATENCY; k++) begin
            data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
        end
        case ({rd_acc, ret})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: the backing store has no reset branch on purpose -- contents must
    // survive rst_n, and a reset port would also block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (mem.wr_datastrb[b]) mem_q[wr_idx][8*b +: 8] <= mem.wr_data[8*b +: 8];
            end
        end
    end

    // NOTE: state flops take <= so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (cnt_q <= MAX_OUT)
                else $error("host_mem_resp_model: outstanding count %0d over limit", cnt_q);
            assert (!(ret && !rd_acc && (cnt_q == '0)))
                else $error("host_mem_resp_model: outstanding count underflow");
        end
    end
endmodule

// File: tb/tb_host_mem_resp_model.sv
// Directed self-checking bench for host_mem_resp_model (default parameters).
module tb_host_mem_resp_model;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    host_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus ();

    host_mem_resp_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW),
        .MEM_DEPTH(1024), .RD_LATENCY(8), .RD_OUTSTANDING(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] s);
        bus.wr_addr = a; bus.wr_data = d; bus.wr_datastrb = s;
        tick();
        bus.wr_datastrb = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bus.rd_addr = a; bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    // Ticks until rd_data_vld, bounded; cycles reads 40 on timeout.
    task automatic wait_ret(output int cycles, output logic [DW-1:0] data);
        cycles = 0;
        while (!bus.rd_data_vld && cycles < 40) begin
            tick();
            cycles++;
        end
        data = bus.rd_data;
    endtask

    initial begin
        int            cyc, acc, ret, ret_win, bad, rdy_c4, vld_seen;
        logic [DW-1:0] d, exp_mask;

        rst_n = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_datastrb = '0;
        bus.rd_addr = '0; bus.rd_en = 1'b0;
        #23;
        check("rst_vld",    DW'(bus.rd_data_vld), DW'(0));
        check("rst_data",   bus.rd_data,          '0);
        rst_n = 1'b1;
        tick();
        check("rst_wr_rdy", DW'(bus.wr_cmd_rdy),  DW'(1));
        check("rst_rd_rdy", DW'(bus.rd_cmd_rdy),  DW'(1));

        // Masked overwrite: low 4 bytes 0x55, remaining bytes 0xAA.
        do_write(64'h40, {MW{8'hAA}}, {MW{1'b1}});
        do_write(64'h40, {MW{8'h55}}, MW'(4'hF));
        do_read(64'h40);
        wait_ret(cyc, d);
        exp_mask = {{(MW-4){8'hAA}}, {4{8'h55}}};
        check("mask_latency", DW'(cyc), DW'(7));
        check("mask_data",    d,        exp_mask);
        tick(); tick();

        // Back-to-back reads of words 1..3 return in order, no gaps.
        for (int i = 1; i <= 3; i++) do_write(AW'(i * 64), DW'(i), {MW{1'b1}});
        bus.rd_en = 1'b1;
        bus.rd_addr = 64'd64;  tick();
        bus.rd_addr = 64'd128; tick();
        bus.rd_addr = 64'd192; tick();
        bus.rd_en = 1'b0;
        wait_ret(cyc, d);
        check("order_latency", DW'(cyc), DW'(5));
        check("order_d1", d, DW'(1));
        tick();
        check("order_v2", DW'(bus.rd_data_vld), DW'(1));
        check("order_d2", bus.rd_data, DW'(2));
        tick();
        check("order_v3", DW'(bus.rd_data_vld), DW'(1));
        check("order_d3", bus.rd_data, DW'(3));
        tick();
        check("order_gap", DW'(bus.rd_data_vld), DW'(0));
        check("order_hold", bus.rd_data, DW'(3));
        tick(); tick();

        // rd_en held 20 cycles: accepts at 0-3, 9-12, 18-19 with limit 4, latency 8.
        acc = 0; ret = 0; ret_win = 0; bad = 0; rdy_c4 = -1;
        bus.rd_addr = 64'd64; bus.rd_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) rdy_c4 = int'(bus.rd_cmd_rdy);
            if (bus.rd_cmd_rdy) acc++;
            tick();
            if (bus.rd_data_vld) begin
                ret_win++;
                if (bus.rd_data !== DW'(1)) bad++;
            end
        end
        bus.rd_en = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus.rd_data_vld) begin
                ret++;
                if (bus.rd_data !== DW'(1)) bad++;
            end
        end
        check("out_rdy_drop",   DW'(rdy_c4),        DW'(0));
        check("out_accepts",    DW'(acc),           DW'(10));
        check("out_ret_window", DW'(ret_win),       DW'(8));
        check("out_ret_total",  DW'(ret + ret_win), DW'(10));
        check("out_ret_data",   DW'(bad),           DW'(0));
        check("out_rdy_idle",   DW'(bus.rd_cmd_rdy), DW'(1));

        // Same-cycle write and read of word 5 returns the new data.
        do_write(64'd320, {MW{8'hFF}}, {MW{1'b1}});
        bus.wr_addr = 64'd320; bus.wr_data = DW'(16'h1234); bus.wr_datastrb = {MW{1'b1}};
        bus.rd_addr = 64'd320; bus.rd_en = 1'b1;
        tick();
        bus.wr_datastrb = '0; bus.rd_en = 1'b0;
        wait_ret(cyc, d);
        check("fwd_latency", DW'(cyc), DW'(7));
        check("fwd_data",    d,        DW'(16'h1234));
        tick(); tick();

        // Reset with three reads in flight discards them; memory survives.
        bus.rd_en = 1'b1;
        bus.rd_addr = 64'd64;  tick();
        bus.rd_addr = 64'd128; tick();
        bus.rd_addr = 64'd192; tick();
        bus.rd_en = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  DW'(bus.rd_data_vld), DW'(0));
        check("mid_rst_data", bus.rd_data, '0);
        tick();
        rst_n = 1'b1;
        vld_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.rd_data_vld) vld_seen++;
        end
        check("mid_rst_noret", DW'(vld_seen), DW'(0));
        check("mid_rst_rdy",   DW'(bus.rd_cmd_rdy), DW'(1));
        do_read(64'd64);
        wait_ret(cyc, d);
        check("mid_rst_keep", d, DW'(1));
        tick(); tick();

        // Word index wraps modulo MEM_DEPTH; byte-offset bits are ignored.
        do_write(64'h40 + 64'd1024 * 64, DW'(64'hDEAD_BEEF_CAFE_F00D), {MW{1'b1}});
        do_read(64'h45);
        wait_ret(cyc, d);
        check("alias_data", d, DW'(64'hDEAD_BEEF_CAFE_F00D));
        do_write(64'h8000_0000_0000_0080, DW'(32'h0BAD_F00D), {MW{1'b1}});
        do_read(64'h80);
        wait_ret(cyc, d);
        check("alias_hi_data", d, DW'(32'h0BAD_F00D));
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
